// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter slice:
// register/data widths, the zero register, and the mul/div queue entry.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One buffered mul/div result; live=0 means the write was superseded
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } q_entry_t;

  // True when entry e still owes a write to register a (r0 never matches)
  function automatic logic addr_hit(input q_entry_t e, input logic [REG_ADDR_W-1:0] a);
    return e.live && (a != REG_ZERO) && (e.addr == a);
  endfunction

endpackage

// File: rtl/rf_wr_queue.sv
// Valid-bit FIFO for mul/div results waiting on the register file write port.
// Entries can be killed in place when a younger pipeline write hits the same
// register; killed entries still occupy their slot until popped.
module rf_wr_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] match_addr_a,
  input  logic [REG_ADDR_W-1:0] match_addr_b,
  output q_entry_t              head,
  output logic                  empty,
  output logic                  full,
  output logic                  will_empty,
  output logic                  match_a,
  output logic                  match_b
);

  localparam int PTR_W = $clog2(DEPTH);

  q_entry_t           entries [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_next;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = entries[rd_ptr];

  // Occupancy after this edge; the top uses it to clear the starvation count
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + (PTR_W+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - (PTR_W+1)'(1);
    end
  end

  assign will_empty = (count_next == '0);

  // Hazard lookup: any live entry targeting either decode source register
  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_hit(entries[i], match_addr_a)) match_a = 1'b1;
      if (addr_hit(entries[i], match_addr_b)) match_b = 1'b1;
    end
  end

  // Storage update: kill matches first, retire the popped slot, then push
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && addr_hit(entries[i], kill_addr)) begin
          entries[i].live <= 1'b0;
        end
      end
      if (pop_ok) begin
        entries[rd_ptr].live <= 1'b0;
        rd_ptr               <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        entries[wr_ptr].live <= 1'b1;
        entries[wr_ptr].addr <= push_addr;
        entries[wr_ptr].data <= push_data;
        wr_ptr               <= wr_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register file write port between pipeline writeback
// (always wins) and buffered mul/div results, drives decode hazard flags,
// and freezes writeback for a cycle when a queued result starves.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  wb_stall,
  output logic                  WrC,
  output logic [REG_ADDR_W-1:0] AddrC,
  output logic [DATA_W-1:0]     WrtDataC
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  q_entry_t          head;
  logic              q_empty;
  logic              q_full;
  logic              q_will_empty;
  logic              q_match_a;
  logic              q_match_b;
  logic              wb_grant;
  logic              head_live;
  logic              q_pop;
  logic              q_push;
  logic              live_pop;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  assign wb_grant  = wb_we && (wb_addr != REG_ZERO);
  assign head_live = !q_empty && head.live;
  // Dead heads always leave; a live head leaves only when it gets the port
  assign q_pop     = !q_empty && (!head.live || !wb_grant);
  assign live_pop  = head_live && !wb_grant;
  assign md_ready  = !q_full && !reset;
  // Writes to r0 complete the handshake but are never buffered
  assign q_push    = md_valid && md_ready && (md_addr != REG_ZERO);

  rf_wr_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_addr   (md_addr),
    .push_data   (md_data),
    .pop         (q_pop),
    .kill        (wb_grant),
    .kill_addr   (wb_addr),
    .match_addr_a(rd_addr_a),
    .match_addr_b(rd_addr_b),
    .head        (head),
    .empty       (q_empty),
    .full        (q_full),
    .will_empty  (q_will_empty),
    .match_a     (q_match_a),
    .match_b     (q_match_b)
  );

  assign hazard_a = !reset && q_match_a;
  assign hazard_b = !reset && q_match_b;

  // Write port mux: pipeline first, then a live queue head, else idle
  always_comb begin
    WrC      = 1'b0;
    AddrC    = REG_ZERO;
    WrtDataC = '0;
    if (!reset) begin
      if (wb_grant) begin
        WrC      = 1'b1;
        AddrC    = wb_addr;
        WrtDataC = wb_data;
      end else if (head_live) begin
        WrC      = 1'b1;
        AddrC    = head.addr;
        WrtDataC = head.data;
      end
    end
  end

  // Starvation count: cleared by a live drain or an empty queue, saturating otherwise
  always_comb begin
    cnt_next = cnt;
    if (live_pop || q_will_empty) begin
      cnt_next = '0;
    end else if (head_live && cnt != CNT_W'(STARVE_MAX)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Registered starvation state and the writeback freeze request
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      wb_stall <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      wb_stall <= (cnt_next == CNT_W'(STARVE_MAX));
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle mul/div unit. Pipeline writeback has priority; mul/div results are buffered in a small queue and drained into free write slots. The block also exposes per-read-port hazard flags for decode and forces a one-cycle pipeline freeze if a queued result starves. It sits between the WB stage and mul/div unit on one side and the register file write port (`WrC`/`AddrC`/`WrtDataC`) on the other.

## Interface
Parameters:
- `DEPTH`, 2: mul/div result queue entries (power of 2, ≥2).
- `STARVE_MAX`, 4: consecutive non-drain cycles before a freeze is forced (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_we` in 1: pipeline WB write enable.
- `wb_addr` in 5: pipeline WB destination.
- `wb_data` in 32: pipeline WB data.
- `md_valid` in 1: mul/div result valid.
- `md_ready` out 1: queue can accept.
- `md_addr` in 5: mul/div destination.
- `md_data` in 32: mul/div result.
- `rd_addr_a` in 5: decode source A.
- `rd_addr_b` in 5: decode source B.
- `hazard_a` out 1: `rd_addr_a` has a pending queued write.
- `hazard_b` out 1: `rd_addr_b` has a pending queued write.
- `wb_stall` out 1: registered; pipeline must freeze WB and drive `wb_we=0` this cycle.
- `WrC` out 1: register file write enable.
- `AddrC` out 5: register file write address.
- `WrtDataC` out 32: register file write data.

## Operation
- **Queue.** `DEPTH` entries of {live, addr, data}, in FIFO order.
  - `md_ready = !full && !reset`.
  - Push on `md_valid && md_ready`.
  - `md_addr==0` is handshaken but not enqueued.
- **Port grant.** Evaluated each cycle, combinational outputs:
  1. If `wb_we && wb_addr!=0`: `WrC=1`, `AddrC=wb_addr`, `WrtDataC=wb_data`.
  2. Else if the head is live: write the head, then pop it.
  3. Else `WrC=0`, with `AddrC`/`WrtDataC` driven 0.
- **Killed head.** A head with live=0 is popped in any cycle, with no write and regardless of grant.
- **WAW kill.** When the pipeline writes address X, every queued live entry with addr X is marked live=0 at that edge, since the younger write wins. An entry pushed in the same cycle with addr X is enqueued live=1, because the mul/div result is younger.
- **Push when full.** A push is never accepted while full, even if a pop occurs that cycle.
- **Hazard flags.** `hazard_a = rd_addr_a!=0 && ∃ live entry with addr==rd_addr_a`; `hazard_b` likewise. Combinational from the queue state; in-flight `md_*` is not included.
- **Starvation counter `cnt`** (saturating, 0..`STARVE_MAX`):
  - Resets to 0 on a live pop or when the queue is empty after the edge.
  - Otherwise increments while a live head waits.
- **`wb_stall`** is the flop `cnt_next==STARVE_MAX`.
  - While `wb_stall=1`, the head drains through rule 2.
  - If `wb_we=1` arrives anyway (protocol violation), the pipeline still wins, `cnt` stays saturated and `wb_stall` stays high.

## Timing
- Reset: queue empty (all live=0, pointers 0), `cnt=0`, `wb_stall=0`, `md_ready=0` during reset and 1 in the first cycle after.
- During reset, `WrC=0` and `hazard_a`/`hazard_b`=0.
- Pipeline write latency: 0 cycles (combinational to the port; the register file commits at the same edge).
- Mul/div write latency: earliest 1 cycle after the push edge, if the port is free.
- With `STARVE_MAX=4`, `wb_wb_stall` rises after 4 consecutive blocked cycles and falls the cycle after the head pops.
- Reset asserted mid-operation: queued results are discarded.
- Same-register priority: pipeline write vs. live head on the same register in the same cycle → pipeline written, head killed.

## Structure
- Shared package `rf_pkg`: `REG_ADDR_W=5`, `DATA_W=32`, `REG_ZERO=5'd0`, and the queue entry typedef {live, addr, data}.
- Sub-module `rf_wr_queue`: the valid-bit FIFO with push/pop, per-entry address-match kill, and match outputs for the two hazard addresses.
- The arbiter top holds the grant mux, starvation counter and `wb_stall` flop.

## Test plan
- Idle port, `md_valid=1`, `md_addr=5`, `md_data=0xDEAD` → `md_ready=1` that cycle, `hazard_a=1` for `rd_addr_a=5` next cycle, then `WrC=1`, `AddrC=5`, `WrtDataC=0xDEAD` in that same cycle, and the queue is empty after.
- Queue full (`DEPTH=2`) with continuous `wb_we` to `r1` → `md_ready=0`, `wb_stall=1` after 4 cycles. In the stall cycle with `wb_we=0` → head written, `wb_stall=0` next cycle.
- Queue holds `r7`=0x11; pipeline writes `r7`=0x22 → `r7` written with 0x22, entry killed, dropped next cycle with `WrC=0`, and no later 0x11 write occurs.
- `md_addr=0` with `md_valid=1` → handshake accepted, queue unchanged, no write.
- Reset asserted with 2 live entries → `WrC=0`, `md_ready=0`, `hazard_a=0`. The first cycle after reset has `md_ready=1`, and no stale entries are written.
